// File: rtl/memory_arbiter.sv
// Two-to-one arbiter sharing one single-ported memory between instruction fetch and data ports.
// Registered request onto the shared port, one-cycle acks, and a watchdog that aborts hung accesses.
module memory_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int DATA_PRIORITY  = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   output logic                    i_ack,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_ack,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ack,
   output logic                    timeout_err
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0]         TO_LIMIT   = CW'(TIMEOUT_CYCLES);
   localparam logic [DATA_WIDTH-1:0] ABORT_DATA = DATA_WIDTH'(32'hDEADBEEF);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t                  state_q;
   logic                    mem_req_q, mem_we_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [SW-1:0]           mem_wstrb_q;
   logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;
   logic                    i_ack_q, d_ack_q, timeout_err_q;
   logic                    last_d_q;
   logic [CW-1:0]           wdog_q;

   logic i_elig, d_elig, grant_i, grant_d, wdog_expired;

   // A port whose ack is high this cycle just finished, so it cannot be re-granted yet.
   always_comb begin
      i_elig  = i_req & ~i_ack_q;
      d_elig  = d_req & ~d_ack_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (i_elig && d_elig) begin
         if ((DATA_PRIORITY != 0) || !last_d_q) grant_d = 1'b1;
         else                                   grant_i = 1'b1;
      end else begin
         grant_i = i_elig;
         grant_d = d_elig;
      end
      wdog_expired = (TIMEOUT_CYCLES != 0) && (wdog_q == TO_LIMIT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_wstrb_q   <= '0;
         i_rdata_q     <= '0;
         d_rdata_q     <= '0;
         i_ack_q       <= 1'b0;
         d_ack_q       <= 1'b0;
         timeout_err_q <= 1'b0;
         last_d_q      <= 1'b1;
         wdog_q        <= '0;
      end else begin
         i_ack_q       <= 1'b0;
         d_ack_q       <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_i) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= i_addr;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
                  last_d_q    <= 1'b0;
                  wdog_q      <= '0;
                  state_q     <= BUSY_I;
               end else if (grant_d) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= d_we;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
                  mem_wstrb_q <= d_we ? d_wstrb : '0;
                  last_d_q    <= 1'b1;
                  wdog_q      <= '0;
                  state_q     <= BUSY_D;
               end
            end
            BUSY_I, BUSY_D: begin
               // A real ack wins over a watchdog expiring in the same cycle.
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= IDLE;
                  if (state_q == BUSY_I) begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= mem_rdata;
                  end else begin
                     d_ack_q <= 1'b1;
                     if (!mem_we_q) d_rdata_q <= mem_rdata;
                  end
               end else if (wdog_expired) begin
                  mem_req_q     <= 1'b0;
                  timeout_err_q <= 1'b1;
                  state_q       <= IDLE;
                  if (state_q == BUSY_I) begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= ABORT_DATA;
                  end else begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= ABORT_DATA;
                  end
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_wstrb   = mem_wstrb_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_ack       = i_ack_q;
   assign d_ack       = d_ack_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench: dut0 alternates on contention, dut1 gives the data port priority; both time out after 4 cycles.
module tb_memory_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // dut0: DATA_PRIORITY=0
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_wstrb;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_ack, d_ack, mem_req, mem_we, timeout_err;
   logic [3:0]  mem_wstrb;

   // dut1: DATA_PRIORITY=1
   logic        i_req1, d_req1, d_we1, mem_ack1;
   logic [31:0] i_addr1, d_addr1, d_wdata1, mem_rdata1;
   logic [3:0]  d_wstrb1;
   logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
   logic        i_ack1, d_ack1, mem_req1, mem_we1, timeout_err1;
   logic [3:0]  mem_wstrb1;

   int errors = 0;
   int checks = 0;

   memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(4)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_wstrb(d_wstrb1),
      .d_rdata(d_rdata1), .d_ack(d_ack1),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_wstrb(mem_wstrb1), .mem_rdata(mem_rdata1), .mem_ack(mem_ack1), .timeout_err(timeout_err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic is_i;
      reset_n = 1'b0;
      i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
      i_req1 = 0; d_req1 = 0; d_we1 = 0; mem_ack1 = 0;
      i_addr1 = '0; d_addr1 = '0; d_wdata1 = '0; d_wstrb1 = '0; mem_rdata1 = '0;

      // Reset values
      repeat (2) tick;
      chk("rst_mem_req",   32'(mem_req), 32'd0);
      chk("rst_mem_we",    32'(mem_we), 32'd0);
      chk("rst_mem_addr",  mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_acks",      32'({i_ack, d_ack}), 32'd0);
      chk("rst_i_rdata",   i_rdata, 32'd0);
      chk("rst_d_rdata",   d_rdata, 32'd0);
      chk("rst_terr",      32'(timeout_err), 32'd0);
      chk("rst_mem_req1",  32'(mem_req1), 32'd0);
      reset_n = 1'b1;
      tick;

      // Contention, alternating, zero-wait memory: I, D, I, D
      i_addr = 32'h200; d_addr = 32'h400; d_we = 0; d_wstrb = 4'hF;
      i_req = 1; d_req = 1;
      for (int k = 0; k < 4; k++) begin
         is_i = (k % 2 == 0);
         tick;
         chk("c0_grant_req", 32'(mem_req), 32'd1);
         chk("c0_grant_addr", mem_addr, is_i ? 32'h200 : 32'h400);
         chk("c0_grant_noack", 32'({i_ack, d_ack}), 32'd0);
         mem_ack = 1; mem_rdata = 32'hA0 + 32'(k);
         tick;
         mem_ack = 0;
         if (k == 3) begin i_req = 0; d_req = 0; end
         chk("c0_i_ack", 32'(i_ack), 32'(is_i));
         chk("c0_d_ack", 32'(d_ack), 32'(!is_i));
         chk("c0_rdata", is_i ? i_rdata : d_rdata, 32'hA0 + 32'(k));
         chk("c0_mem_req_low", 32'(mem_req), 32'd0);
      end
      tick;
      chk("c0_drain", 32'(mem_req), 32'd0);

      // Single fetch, memory acks one cycle after mem_req
      i_addr = 32'h100; i_req = 1;
      tick;
      chk("f_req",   32'(mem_req), 32'd1);
      chk("f_addr",  mem_addr, 32'h100);
      chk("f_we",    32'(mem_we), 32'd0);
      chk("f_wstrb", 32'(mem_wstrb), 32'd0);
      tick;
      chk("f_wait", 32'(i_ack), 32'd0);
      mem_ack = 1; mem_rdata = 32'h13;
      tick;
      mem_ack = 0; i_req = 0;
      chk("f_iack",   32'(i_ack), 32'd1);
      chk("f_rdata",  i_rdata, 32'h13);
      chk("f_dack",   32'(d_ack), 32'd0);
      chk("f_memreq", 32'(mem_req), 32'd0);
      tick;
      chk("f_pulse", 32'({i_ack, d_ack}), 32'd0);

      // Data read: strobes masked to 0
      d_we = 0; d_addr = 32'h3000; d_wstrb = 4'hF; d_wdata = 32'h55555555; d_req = 1;
      tick;
      chk("r_addr",  mem_addr, 32'h3000);
      chk("r_we",    32'(mem_we), 32'd0);
      chk("r_wstrb", 32'(mem_wstrb), 32'd0);
      mem_ack = 1; mem_rdata = 32'h12345678;
      tick;
      mem_ack = 0; d_req = 0;
      chk("r_dack",  32'(d_ack), 32'd1);
      chk("r_rdata", d_rdata, 32'h12345678);
      tick;

      // Data write
      d_we = 1; d_addr = 32'h2004; d_wdata = 32'hCAFEBABE; d_wstrb = 4'b0011; d_req = 1;
      tick;
      chk("w_we",    32'(mem_we), 32'd1);
      chk("w_addr",  mem_addr, 32'h2004);
      chk("w_wdata", mem_wdata, 32'hCAFEBABE);
      chk("w_wstrb", 32'(mem_wstrb), 32'h3);
      mem_ack = 1; mem_rdata = 32'hFFFF0000;
      tick;
      mem_ack = 0; d_req = 0; d_we = 0;
      chk("w_dack",    32'(d_ack), 32'd1);
      chk("w_rdata",   d_rdata, 32'h12345678);
      chk("w_iack",    32'(i_ack), 32'd0);
      chk("w_i_rdata", i_rdata, 32'h13);
      tick;
      chk("w_pulse", 32'(d_ack), 32'd0);

      // Watchdog abort on a data read: ack on the 5th BUSY edge
      d_addr = 32'h500; d_we = 0; d_req = 1;
      tick;
      chk("wd_req", 32'(mem_req), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("wd_busy_ack",  32'(d_ack), 32'd0);
         chk("wd_busy_terr", 32'(timeout_err), 32'd0);
         chk("wd_busy_req",  32'(mem_req), 32'd1);
      end
      tick;
      d_req = 0;
      chk("wd_dack",   32'(d_ack), 32'd1);
      chk("wd_rdata",  d_rdata, 32'hDEADBEEF);
      chk("wd_terr",   32'(timeout_err), 32'd1);
      chk("wd_memreq", 32'(mem_req), 32'd0);
      tick;
      chk("wd_terr_pulse", 32'(timeout_err), 32'd0);
      chk("wd_idle",       32'({mem_req, d_ack}), 32'd0);

      // mem_ack in the limit cycle completes normally
      i_addr = 32'h600; i_req = 1;
      tick;
      repeat (4) tick;
      mem_ack = 1; mem_rdata = 32'h77;
      tick;
      mem_ack = 0; i_req = 0;
      chk("p_iack",  32'(i_ack), 32'd1);
      chk("p_rdata", i_rdata, 32'h77);
      chk("p_terr",  32'(timeout_err), 32'd0);
      tick;

      // Asynchronous reset while BUSY_D
      d_we = 1; d_addr = 32'h700; d_wdata = 32'h0BADF00D; d_wstrb = 4'hF; d_req = 1;
      tick;
      chk("rs_busy", 32'({mem_req, mem_we}), 32'h3);
      #2 reset_n = 1'b0;
      #1;
      chk("rs_mem_req",   32'(mem_req), 32'd0);
      chk("rs_mem_we",    32'(mem_we), 32'd0);
      chk("rs_mem_addr",  mem_addr, 32'd0);
      chk("rs_mem_wdata", mem_wdata, 32'd0);
      chk("rs_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rs_i_rdata",   i_rdata, 32'd0);
      chk("rs_d_rdata",   d_rdata, 32'd0);
      chk("rs_acks",      32'({i_ack, d_ack, timeout_err}), 32'd0);
      tick;
      reset_n = 1'b1;
      d_we = 0; i_addr = 32'h800; d_addr = 32'h900; i_req = 1; d_req = 1;
      tick;
      chk("rs_no_stale", 32'(d_ack), 32'd0);
      chk("rs_first_i",  mem_addr, 32'h800);
      chk("rs_req",      32'(mem_req), 32'd1);
      mem_ack = 1; mem_rdata = 32'h88;
      tick;
      mem_ack = 0; i_req = 0;
      chk("rs_iack", 32'({i_ack, d_ack}), 32'h2);
      tick;
      chk("rs_then_d", mem_addr, 32'h900);
      mem_ack = 1; mem_rdata = 32'h99;
      tick;
      mem_ack = 0; d_req = 0;
      chk("rs_dack",  32'({i_ack, d_ack}), 32'h1);
      chk("rs_drdat", d_rdata, 32'h99);
      tick;

      // Data priority (dut1): D wins real contention, I gets the cycle after each D ack
      i_addr1 = 32'h10; d_addr1 = 32'h20; i_req1 = 1; d_req1 = 1;
      for (int k = 0; k < 3; k++) begin
         is_i = (k == 1);
         tick;
         chk("p1_grant_addr", mem_addr1, is_i ? 32'h10 : 32'h20);
         chk("p1_grant_req",  32'(mem_req1), 32'd1);
         mem_ack1 = 1;
         tick;
         mem_ack1 = 0;
         if (k == 2) d_req1 = 0;
         chk("p1_ack", 32'({i_ack1, d_ack1}), is_i ? 32'h2 : 32'h1);
      end
      tick;
      chk("p1_i_only", mem_addr1, 32'h10);
      mem_ack1 = 1;
      tick;
      mem_ack1 = 0; i_req1 = 0;
      chk("p1_i_ack",  32'(i_ack1), 32'd1);
      chk("p1_terr",   32'(timeout_err1), 32'd0);
      chk("p1_we",     32'({mem_we1, mem_wstrb1}), 32'd0);
      chk("p1_wdata",  mem_wdata1, 32'd0);
      chk("p1_rdata",  i_rdata1 | d_rdata1, 32'd0);
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
